// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared word/address widths and fetch FSM state encoding
package hack_pkg;

    localparam int WORD_W     = 16;
    localparam int ROM_ADDR_W = 15;

    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - ROM read bus and decode handshake bundle for the fetch stage
//   master (fetch side): drives rom_addr, rom_rd_en, instr_out, instr_pc, instr_valid
//   slave  (environment): drives rom_data, instr_ready
interface instruction_fetch_if #(
    parameter int DATA_W = hack_pkg::WORD_W,
    parameter int ADDR_W = hack_pkg::ROM_ADDR_W
);

    logic [ADDR_W-1:0]          rom_addr;
    logic                       rom_rd_en;
    logic [DATA_W-1:0]          rom_data;
    logic [DATA_W-1:0]          instr_out;
    logic [hack_pkg::WORD_W-1:0] instr_pc;
    logic                       instr_valid;
    logic                       instr_ready;

    modport master (
        output rom_addr, rom_rd_en, instr_out, instr_pc, instr_valid,
        input  rom_data, instr_ready
    );

    modport slave (
        input  rom_addr, rom_rd_en, instr_out, instr_pc, instr_valid,
        output rom_data, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small FIFO holding fetched {instruction, pc} entries
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous discard of all entries (wins over push)
//   push/push_data, pop : write tail / drop head
//   head_data    : current head entry
//   count        : number of valid entries (0..DEPTH)
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged, including when full.
            count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: issues ROM reads from pc_in, buffers words for decode
//   clk, reset_n  : clock, asynchronous active-low reset
//   pc_in         : current program counter
//   pc_increment  : advance the program counter (high exactly when a read issues)
//   flush         : jump taken; discards buffered and in-flight words
//   bus (master)  : ROM read port and decode-side instr_valid/instr_ready handshake
module instruction_fetch
    import hack_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] pc_in,
    output logic              pc_increment,
    input  logic              flush,
    instruction_fetch_if.master bus
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_W + WORD_W;

    fetch_state_e      state_q, state_d;
    logic              inflight_q, inflight_d;
    logic [WORD_W-1:0] tag_q, tag_d;

    logic [PTR_W:0]    count;
    logic [PTR_W+1:0]  credit;
    logic [ENTRY_W-1:0] head;
    logic              pop;
    logic              push;
    logic              issue;

    assign bus.instr_valid = (count != '0);
    assign pop             = bus.instr_valid & bus.instr_ready;
    // A word returning in the flush cycle belongs to the old path and is dropped.
    assign push            = inflight_q & ~flush;

    // Slots already committed (buffered + in flight) after this cycle's pop; pop implies
    // count >= 1, so this never underflows.
    assign credit = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight_q}
                  - {{(PTR_W+1){1'b0}}, pop};

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        case (state_q)
            // One idle cycle lets the program counter leave its own reset.
            FETCH_BOOT: state_d = FETCH_RUN;
            FETCH_RUN: begin
                state_d = FETCH_RUN;
                if (!flush && (credit < (PTR_W+2)'(DEPTH))) begin
                    issue = 1'b1;
                end
            end
            default: state_d = FETCH_BOOT;
        endcase
        if (issue) begin
            inflight_d = 1'b1;
            tag_d      = pc_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH_BOOT;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    assign pc_increment  = issue;
    assign bus.rom_rd_en = issue;
    assign bus.rom_addr  = issue ? pc_in[ADDR_W-1:0] : '0;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (push),
        .push_data ({bus.rom_data, tag_q}),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    assign bus.instr_out = head[ENTRY_W-1:WORD_W];
    assign bus.instr_pc  = head[WORD_W-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch with ROM and PC models
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc_in;
    logic        pc_increment;
    logic        flush;
    logic [15:0] flush_target;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_in        (pc_in),
        .pc_increment (pc_increment),
        .flush        (flush),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [14:0] a);
        return 16'h1000 + {1'b0, a};
    endfunction

    // Synchronous ROM: data for the address presented with rd_en appears after the edge.
    always @(posedge clk) begin
        if (bus.rom_rd_en) bus.rom_data <= rom_word(bus.rom_addr);
    end

    // Program counter: load on flush, advance on pc_increment.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)          pc_in <= 16'h0000;
        else if (flush)        pc_in <= flush_target;
        else if (pc_increment) pc_in <= pc_in + 16'h0001;
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic assert_reset(input logic rdy);
        reset_n         = 1'b0;
        bus.instr_ready = rdy;
        flush           = 1'b0;
        exp_q.delete();
        #1;
        check_eq("reset_outputs",
                 {bus.instr_valid, bus.rom_rd_en, pc_increment, bus.rom_addr,
                  bus.instr_out, bus.instr_pc}, 64'h0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_eq("boot_no_issue", bus.rom_rd_en, 1'b0);
        @(negedge clk);
        check_eq("first_issue", {bus.rom_rd_en, bus.rom_addr}, {1'b1, 15'h0000});
    endtask

    task automatic push_range(input logic [15:0] first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(first + 16'(k));
    endtask

    task automatic wait_drain(input int bound, input bit drop);
        int n = 0;
        bus.instr_ready = 1'b1;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
        if (drop) bus.instr_ready = 1'b0;
    endtask

    task automatic do_flush(input logic [15:0] target);
        @(posedge clk);
        #1;
        flush        = 1'b1;
        flush_target = target;
        @(negedge clk);
        check_eq("flush_no_issue", {bus.rom_rd_en, pc_increment}, 2'b00);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_eq("flush_kills_valid", bus.instr_valid, 1'b0);
        check_eq("refetch", {bus.rom_rd_en, bus.rom_addr}, {1'b1, target[14:0]});
    endtask

    initial begin
        int          lat;
        int          hi;
        int          inc;
        logic [15:0] pat;
        logic [15:0] e;

        reset_n         = 1'b0;
        flush           = 1'b0;
        flush_target    = 16'h0000;
        bus.instr_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (reset_n) begin
                    check_eq("inc_eq_rd_en", pc_increment, bus.rom_rd_en);
                    if (bus.rom_rd_en) check_eq("rom_addr", bus.rom_addr, pc_in[14:0]);
                    if (bus.instr_valid && bus.instr_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_instr actual_pc=%h required=none",
                                     bus.instr_pc);
                        end else begin
                            e = exp_q.pop_front();
                            check_eq("instr_pc", bus.instr_pc, e);
                            check_eq("instr_out", bus.instr_out, rom_word(e[14:0]));
                        end
                    end
                end
            end
        join_none

        // Test 1: streaming from pc 0 with decode always ready.
        @(posedge clk);
        #2 assert_reset(1'b1);
        release_reset();
        push_range(16'h0000, 8);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (bus.instr_valid) break;
        end
        check_eq("fetch_latency", lat, 2);
        hi = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            hi += int'(bus.instr_valid);
        end
        check_eq("back_to_back", hi, 7);
        wait_drain(40, 1'b1);

        // Test 2/4: decode stalled from the start, then irregular ready.
        @(posedge clk);
        #2 assert_reset(1'b0);
        release_reset();
        inc = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            inc += int'(pc_increment);
        end
        check_eq("stall_issues", inc, 2);
        check_eq("stall_valid", bus.instr_valid, 1'b1);
        push_range(16'h0000, 12);
        pat = 16'hB396;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 bus.instr_ready = pat[i];
        end
        wait_drain(60, 1'b1);

        // Test 3: flush with buffered and in-flight words from the old path.
        @(posedge clk);
        #2 assert_reset(1'b1);
        release_reset();
        push_range(16'h0000, 5);
        wait_drain(40, 1'b1);
        do_flush(16'h0040);
        push_range(16'h0040, 6);
        wait_drain(40, 1'b0);

        // Test 5: asynchronous reset between edges while streaming.
        #1 check_eq("valid_before_reset", bus.instr_valid, 1'b1);
        #1 assert_reset(1'b1);
        check_eq("reset_drops_now", {bus.instr_valid, bus.rom_rd_en, pc_increment}, 3'b000);
        release_reset();
        push_range(16'h0000, 4);
        wait_drain(40, 1'b1);

        // Test 6: ROM address width boundary and 16-bit pc wrap.
        do_flush(16'h7FFE);
        push_range(16'h7FFE, 4);
        wait_drain(40, 1'b1);
        do_flush(16'hFFFE);
        push_range(16'hFFFE, 4);
        wait_drain(40, 1'b1);

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
